// File: rtl/logic_result_fifo.sv
// logic_result_fifo
// Result buffer behind the 8-bit logic unit. Captures {opcode, result} on a
// strobe, holds up to DEPTH entries and hands them out with valid/ready.
// Strobes while the unit flags an unsupported opcode are counted as errors;
// pushes lost to a full buffer are counted as drops. Both counters saturate.
module logic_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [1:8]               in_data,
  input  logic                     in_valid,
  input  logic [1:3]               in_select,
  input  logic                     in_strobe,
  output logic [1:8]               out_data,
  output logic [1:3]               out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 11;
  localparam logic [OCC_W-1:0] LP_DEPTH   = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

  // Storage and state registers
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Event decode and next-state values
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic             w_drop;
  logic             w_err;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [OCC_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_drop_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [ENT_W-1:0] w_head;

  // Decode push/pop/drop/error events from the current registered state
  always_comb begin
    w_pop      = ~r_empty & out_ready;
    w_push_req = in_strobe & in_valid;
    // A full buffer still accepts a push when the head leaves in the same cycle
    w_push     = w_push_req & (~r_full | w_pop);
    w_drop     = w_push_req & r_full & ~w_pop;
    w_err      = in_strobe & ~in_valid;
  end

  // Next-state for pointers, occupancy and saturating counters; clr wins
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_drop_nxt   = r_drop_cnt;
    w_err_nxt    = r_err_cnt;
    if (clr) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
      w_drop_nxt   = '0;
      w_err_nxt    = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + OCC_W'(1);
        2'b01:   w_count_nxt = r_count - OCC_W'(1);
        default: w_count_nxt = r_count;
      endcase
      if (w_drop && (r_drop_cnt != LP_CNT_MAX)) begin
        w_drop_nxt = r_drop_cnt + CNT_W'(1);
      end else begin
        w_drop_nxt = r_drop_cnt;
      end
      if (w_err && (r_err_cnt != LP_CNT_MAX)) begin
        w_err_nxt = r_err_cnt + CNT_W'(1);
      end else begin
        w_err_nxt = r_err_cnt;
      end
    end
  end

  // Control and status registers; full/empty are precomputed from next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == LP_DEPTH);
      r_empty    <= (w_count_nxt == OCC_W'(0));
      r_drop_cnt <= w_drop_nxt;
      r_err_cnt  <= w_err_nxt;
    end
  end

  // Entry storage; when full with a pop, the write lands on the outgoing head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !clr) begin
      r_mem[r_wr_ptr] <= {in_select, in_data};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Head presentation from registers only, masked to zero while empty
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (r_empty) begin
      out_data = 8'h00;
      out_sel  = 3'b000;
    end else begin
      out_data = w_head[7:0];
      out_sel  = w_head[10:8];
    end
    out_valid = ~r_empty;
    full      = r_full;
    empty     = r_empty;
    count     = r_count;
    drop_cnt  = r_drop_cnt;
    err_cnt   = r_err_cnt;
  end

endmodule

// File: doc/logic_result_fifo.md
# logic_result_fifo

Result buffer directly downstream of the 8-bit logic unit. It captures the unit's `out`/`valid` result together with the opcode that produced it whenever a capture strobe is raised, and holds up to DEPTH entries. Entries are presented to the consumer with a valid/ready handshake. Requests made while the unit reports an unsupported opcode are rejected and counted. Overflow drops are counted separately.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_W, 8, width of the saturating drop/error counters.

- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of storage and counters.
- in_data  input  [1:8]  logic unit `out`.
- in_valid  input  1  logic unit `valid`.
- in_select  input  [1:3]  opcode applied to the logic unit this cycle.
- in_strobe  input  1  capture request, one per cycle it is high.
- out_data  output  [1:8]  head entry result.
- out_sel  output  [1:3]  head entry opcode.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  clog2(DEPTH)+1  occupancy.
- drop_cnt  output  CNT_W  pushes lost to overflow, saturating.
- err_cnt  output  CNT_W  strobes with in_valid=0, saturating.

## Operation
- Storage is a DEPTH-entry register array of {sel[1:3], data[1:8]}, plus wr_ptr and rd_ptr of clog2(DEPTH) bits and a separate count register.
- Pointers wrap modulo DEPTH.
- Pop: pop = out_valid & out_ready. On a pop, rd_ptr advances and count decrements.
- Push request: in_strobe=1.
  - If in_valid=0: no write; err_cnt increments (saturating at 2^CNT_W-1).
  - Else if count<DEPTH, or a pop occurs in the same cycle: write {in_select, in_data} at wr_ptr, advance wr_ptr, and increment count unless a pop also occurred.
  - Else (full, no pop): no write; drop_cnt increments (saturating).
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, the freed slot is the one overwritten. The outgoing head is taken before the write.
  - Push and pop on an empty FIFO: no pop happens (out_valid=0), so the entry is simply written.
- Invalid opcode with in_strobe=0: no effect on anything.
- clr=1 has highest priority. Pointers, count, drop_cnt and err_cnt go to 0. Any same-cycle push or pop is ignored and counts nothing. Storage contents need not be cleared.
- out_valid = ~empty. out_data/out_sel = storage[rd_ptr]. These are driven from registers only, with no combinational path from in_* to out_*.
- While out_valid=0, out_data and out_sel read 0 (masked).
- The consumer may hold out_ready high continuously. out_valid never depends on out_ready.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-safe release):
  - out_valid=0, out_data=0, out_sel=0, full=0, empty=1, count=0, drop_cnt=0, err_cnt=0.
  - Pointers are set to 0.
- Write latency: a push accepted at edge N shows at the head no earlier than after edge N.
  - On an empty FIFO: out_valid=1 with that data from edge N onward, i.e. during cycle N+1.
- Pop takes effect at the edge where out_valid & out_ready are sampled high. The next entry, or out_valid=0, appears after that edge.
- full, empty, count, drop_cnt and err_cnt are registered and update at the same edge as the event that changes them.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- Reset asserted mid-transfer discards all entries immediately. Outputs take reset values without waiting for a clock.

## Test plan
- Reset then idle: rst_n low 3 cycles → all outputs 0 except empty=1.
  - Release, 5 idle cycles → unchanged.
- Single push/pop:
  - Strobe with in_data=8'hA5, in_select=3'b010, in_valid=1.
  - Next cycle expect out_valid=1, out_data=A5, out_sel=010, count=1.
  - out_ready=1 one cycle → empty=1, count=0.
- Fill and overflow (DEPTH=4):
  - Push 8'h01..8'h05, out_ready=0 → full=1, count=4, drop_cnt=1.
  - Drain → 01,02,03,04 in order, then empty.
- Full with simultaneous push/pop: while full with head 01, push 8'h99 and set out_ready=1 in the same cycle.
  - Expect drop_cnt unchanged, count=4, head=02.
  - 99 emerges last.
  - Continuous streaming of 16 values with out_ready=1 shows wrap-around with no loss.
- Invalid opcode:
  - Strobe with in_select=3'b111, in_valid=0 → nothing written, err_cnt=1.
  - 300 such strobes → err_cnt saturates at 255.
- Flush and async reset:
  - With 3 entries and nonzero counters, pulse clr while also strobing → count=0, counters=0, nothing written.
  - Refill 2 entries, drop rst_n mid-cycle → out_valid falls immediately without a clock edge.
